datapath_exec: RTL and testbench

Execution end of the controller-to-datapath control bundle: consumes the per-cycle control word (register enables, operand buffer enables, immediate, carry-in, opcode/extended opcode, soft reset) produced by the test-case/instruction controller and executes it on a 16×16-bit register file with an ALU and processor status flags. It is a two-stage pipeline (operand capture, then execute/write-back) with forwarding. It sits directly below the controller and is the unit the processor bench checks register contents against.

---
 rtl/datapath_exec.sv | 183 ++++++++++++++++++
 tb/tb_datapath_exec.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_exec.sv
// Two-stage execute unit: operand capture with forwarding, then ALU execute and write-back
// into a 16-entry register file with {C, L, F, Z, N} status flags.
module datapath_exec #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_out,
    input  logic [WIDTH-1:0] immediate,
    input  logic [4:0]       regEnables,
    input  logic [4:0]       buffAEnables,
    input  logic [4:0]       buffBEnables,
    input  logic             Cin,
    input  logic             regOrImmed,
    input  logic [3:0]       op,
    input  logic [3:0]       exop,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [4:0]       flags,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_ADDU, ALU_ADDC, ALU_SUB, ALU_CMP,
        ALU_AND, ALU_OR, ALU_XOR, ALU_MOV, ALU_LSH
    } alu_op_e;

    localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];

    alu_op_e          ex_op_q, ex_op_d;
    logic [3:0]       ex_dst_q, ex_dst_d;
    logic             ex_we_q, ex_we_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d;
    logic [WIDTH-1:0] ex_b_q, ex_b_d;
    logic             ex_cin_q, ex_cin_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [4:0]       flags_q, flags_d;

    alu_op_e          dec_op;
    logic [WIDTH-1:0] a_rd, b_rd, a_op, b_op;

    logic             add_cin;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] ex_res;
    logic [4:0]       ex_flags;
    logic             ex_vld, ex_wr;

    always_comb begin
        dec_op = ALU_NOP;
        if (op == 4'b0000) begin
            case (exop)
                4'b0101: dec_op = ALU_ADD;
                4'b0110: dec_op = ALU_ADDU;
                4'b0111: dec_op = ALU_ADDC;
                4'b1001: dec_op = ALU_SUB;
                4'b1011: dec_op = ALU_CMP;
                4'b0001: dec_op = ALU_AND;
                4'b0010: dec_op = ALU_OR;
                4'b0011: dec_op = ALU_XOR;
                4'b1101: dec_op = ALU_MOV;
                default: dec_op = ALU_NOP;
            endcase
        end else if (op == 4'b1000) begin
            dec_op = ALU_LSH;
        end
    end

    // The instruction in EX writes back on the same edge that captures the next one,
    // so a matching read must take the EX result rather than the stale register.
    always_comb begin
        a_rd = rf_q[buffAEnables[3:0]];
        b_rd = rf_q[buffBEnables[3:0]];
        if (ex_wr && ex_dst_q == buffAEnables[3:0]) a_rd = ex_res;
        if (ex_wr && ex_dst_q == buffBEnables[3:0]) b_rd = ex_res;
        a_op = buffAEnables[4] ? a_rd : '0;
        if (regOrImmed)
            b_op = immediate;
        else
            b_op = buffBEnables[4] ? b_rd : '0;
    end

    always_comb begin
        case (ex_op_q)
            ALU_ADD:  add_cin = ex_cin_q;
            ALU_ADDC: add_cin = flags_q[FC];
            default:  add_cin = 1'b0;
        endcase
        sum  = {1'b0, ex_a_q} + {1'b0, ex_b_q} + {{WIDTH{1'b0}}, add_cin};
        diff = {1'b0, ex_a_q} - {1'b0, ex_b_q} - {{WIDTH{1'b0}}, ex_cin_q};

        ex_res   = result_q;
        ex_flags = flags_q;
        ex_vld   = 1'b1;
        case (ex_op_q)
            ALU_ADD, ALU_ADDC: begin
                ex_res       = sum[WIDTH-1:0];
                ex_flags[FC] = sum[WIDTH];
                ex_flags[FF] = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) &&
                               (sum[WIDTH-1] != ex_a_q[WIDTH-1]);
            end
            ALU_ADDU: ex_res = sum[WIDTH-1:0];
            ALU_SUB: begin
                ex_res       = diff[WIDTH-1:0];
                ex_flags[FC] = diff[WIDTH];
                ex_flags[FF] = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) &&
                               (diff[WIDTH-1] != ex_a_q[WIDTH-1]);
            end
            ALU_CMP: begin
                ex_res       = ex_a_q - ex_b_q;
                ex_flags[FZ] = (ex_a_q == ex_b_q);
                ex_flags[FL] = (ex_a_q < ex_b_q);
                ex_flags[FN] = ($signed(ex_a_q) < $signed(ex_b_q));
            end
            ALU_AND: ex_res = ex_a_q & ex_b_q;
            ALU_OR:  ex_res = ex_a_q | ex_b_q;
            ALU_XOR: ex_res = ex_a_q ^ ex_b_q;
            ALU_MOV: ex_res = ex_b_q;
            ALU_LSH: ex_res = ex_b_q[4] ? (ex_a_q >> ex_b_q[3:0]) : (ex_a_q << ex_b_q[3:0]);
            default: ex_vld = 1'b0;
        endcase
        ex_wr = ex_vld && ex_we_q && (ex_op_q != ALU_CMP);
    end

    // Soft clear wins over both write-back and capture on the same edge.
    always_comb begin
        rf_d = rf_q;
        if (reset_out) begin
            for (int i = 0; i < NREGS; i++) rf_d[i] = '0;
        end else if (ex_wr) begin
            rf_d[ex_dst_q] = ex_res;
        end

        ex_op_d  = reset_out ? ALU_NOP : dec_op;
        ex_dst_d = regEnables[3:0];
        ex_we_d  = regEnables[4] && !reset_out;
        ex_a_d   = a_op;
        ex_b_d   = b_op;
        ex_cin_d = Cin;

        result_d       = reset_out ? '0 : (ex_vld ? ex_res : result_q);
        result_valid_d = !reset_out && ex_vld;
        flags_d        = reset_out ? 5'b0 : (ex_vld ? ex_flags : flags_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            ex_op_q        <= ALU_NOP;
            ex_dst_q       <= '0;
            ex_we_q        <= 1'b0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_cin_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
            ex_op_q        <= ex_op_d;
            ex_dst_q       <= ex_dst_d;
            ex_we_q        <= ex_we_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_cin_q       <= ex_cin_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            flags_q        <= flags_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign flags        = flags_q;
    assign dbg_data     = rf_q[dbg_addr];

endmodule

// File: tb/tb_datapath_exec.sv
// Directed bench for datapath_exec: a table of single instructions with hand-computed
// results, plus sequences for reset, forwarding, debug read timing and soft clear.
module tb_datapath_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset_out;
    logic [15:0] immediate;
    logic [4:0]  regEnables, buffAEnables, buffBEnables;
    logic        Cin, regOrImmed;
    logic [3:0]  op, exop;
    logic [15:0] result;
    logic        result_valid;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_pass = 0;
    int n_total = 0;

    datapath_exec #(.WIDTH(16), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .reset_out(reset_out), .immediate(immediate),
        .regEnables(regEnables), .buffAEnables(buffAEnables), .buffBEnables(buffBEnables),
        .Cin(Cin), .regOrImmed(regOrImmed), .op(op), .exop(exop),
        .result(result), .result_valid(result_valid), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op, exop, rd;
        logic        we;
        logic [3:0]  ra;
        logic        aen;
        logic [3:0]  rb;
        logic        ben;
        logic [15:0] imm;
        logic        rimm, cin;
        logic [15:0] eres;
        logic        chk_res, evalid;
        logic [4:0]  eflags;
        logic [3:0]  creg;
        logic [15:0] ereg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [3:0] o, input logic [3:0] xo, input logic [3:0] rd,
                         input logic we, input logic [3:0] ra, input logic aen,
                         input logic [3:0] rb, input logic ben, input logic [15:0] imm,
                         input logic rimm, input logic cin);
        op = o; exop = xo; regEnables = {we, rd};
        buffAEnables = {aen, ra}; buffBEnables = {ben, rb};
        immediate = imm; regOrImmed = rimm; Cin = cin;
    endtask

    task automatic nop();
        drive(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [3:0] xo, input logic [3:0] rd,
                                input logic we, input logic [3:0] ra, input logic aen,
                                input logic [3:0] rb, input logic ben, input logic [15:0] imm,
                                input logic rimm, input logic cin, input logic [15:0] eres,
                                input logic chk_res, input logic evalid, input logic [4:0] eflags,
                                input logic [3:0] creg, input logic [15:0] ereg);
        vec_t v;
        v.op = o; v.exop = xo; v.rd = rd; v.we = we; v.ra = ra; v.aen = aen;
        v.rb = rb; v.ben = ben; v.imm = imm; v.rimm = rimm; v.cin = cin;
        v.eres = eres; v.chk_res = chk_res; v.evalid = evalid; v.eflags = eflags;
        v.creg = creg; v.ereg = ereg;
        return v;
    endfunction

    initial begin
        vec_t v;
        // op  exop rd we ra aen rb ben imm rimm cin | res chk valid flags creg reg
        vecs.push_back(mk(0, 4'hD, 1, 1, 0, 0, 0, 0, 16'h1234, 1, 0, 16'h1234, 1, 1, 5'h00, 1, 16'h1234));
        vecs.push_back(mk(0, 4'h5, 2, 1, 1, 1, 0, 0, 16'h0001, 1, 0, 16'h1235, 1, 1, 5'h00, 2, 16'h1235));
        vecs.push_back(mk(0, 4'h5, 3, 1, 1, 1, 2, 1, 16'h0000, 0, 0, 16'h2469, 1, 1, 5'h00, 3, 16'h2469));
        vecs.push_back(mk(0, 4'h5, 9, 1, 0, 0, 0, 0, 16'h0005, 1, 1, 16'h0006, 1, 1, 5'h00, 9, 16'h0006));
        vecs.push_back(mk(0, 4'hD, 4, 1, 0, 0, 0, 0, 16'hFFFF, 1, 0, 16'hFFFF, 1, 1, 5'h00, 4, 16'hFFFF));
        vecs.push_back(mk(0, 4'h5, 3, 1, 4, 1, 0, 0, 16'h0001, 1, 0, 16'h0000, 1, 1, 5'h10, 3, 16'h0000));
        vecs.push_back(mk(0, 4'hD, 5, 1, 0, 0, 0, 0, 16'h7FFF, 1, 0, 16'h7FFF, 1, 1, 5'h10, 5, 16'h7FFF));
        vecs.push_back(mk(0, 4'h7, 8, 1, 5, 1, 0, 0, 16'h0000, 1, 0, 16'h8000, 1, 1, 5'h04, 8, 16'h8000));
        vecs.push_back(mk(0, 4'h5, 6, 1, 5, 1, 0, 0, 16'h0001, 1, 0, 16'h8000, 1, 1, 5'h04, 6, 16'h8000));
        vecs.push_back(mk(0, 4'hB, 7, 1, 6, 1, 0, 0, 16'h0001, 1, 0, 16'h0000, 0, 1, 5'h05, 7, 16'h0000));
        vecs.push_back(mk(0, 4'h9, 9, 1, 1, 1, 0, 0, 16'h1235, 1, 0, 16'hFFFF, 1, 1, 5'h11, 9, 16'hFFFF));
        vecs.push_back(mk(0, 4'h9, 10, 1, 1, 1, 0, 0, 16'h0034, 1, 1, 16'h11FF, 1, 1, 5'h01, 10, 16'h11FF));
        vecs.push_back(mk(0, 4'h9, 11, 1, 6, 1, 0, 0, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 5'h05, 11, 16'h7FFF));
        vecs.push_back(mk(0, 4'h1, 12, 1, 1, 1, 0, 0, 16'h0F0F, 1, 0, 16'h0204, 1, 1, 5'h05, 12, 16'h0204));
        vecs.push_back(mk(0, 4'h2, 13, 1, 1, 1, 0, 0, 16'h00F0, 1, 0, 16'h12F4, 1, 1, 5'h05, 13, 16'h12F4));
        vecs.push_back(mk(0, 4'h3, 14, 1, 1, 1, 0, 0, 16'hFFFF, 1, 0, 16'hEDCB, 1, 1, 5'h05, 14, 16'hEDCB));
        vecs.push_back(mk(0, 4'h6, 15, 1, 4, 1, 0, 0, 16'h0002, 1, 1, 16'h0001, 1, 1, 5'h05, 15, 16'h0001));
        vecs.push_back(mk(0, 4'hD, 0, 1, 0, 0, 0, 0, 16'h0001, 1, 0, 16'h0001, 1, 1, 5'h05, 0, 16'h0001));
        vecs.push_back(mk(8, 4'h0, 0, 1, 0, 1, 0, 0, 16'h0004, 1, 0, 16'h0010, 1, 1, 5'h05, 0, 16'h0010));
        vecs.push_back(mk(8, 4'h0, 7, 1, 6, 1, 0, 0, 16'h0014, 1, 0, 16'h0800, 1, 1, 5'h05, 7, 16'h0800));
        vecs.push_back(mk(4'hF, 4'h0, 2, 1, 1, 1, 0, 0, 16'hDEAD, 1, 0, 16'h0800, 1, 0, 5'h05, 2, 16'h1235));
        vecs.push_back(mk(0, 4'h0, 1, 1, 2, 1, 0, 0, 16'hBEEF, 1, 0, 16'h0800, 1, 0, 5'h05, 1, 16'h1234));
        vecs.push_back(mk(0, 4'hB, 1, 0, 1, 1, 0, 0, 16'h1234, 1, 0, 16'h0000, 0, 1, 5'h06, 1, 16'h1234));
        vecs.push_back(mk(0, 4'hB, 5, 0, 1, 1, 0, 0, 16'h8000, 1, 0, 16'h0000, 0, 1, 5'h0C, 5, 16'h7FFF));

        // Reset held low with arbitrary control words
        reset = 1'b0; reset_out = 1'b0; dbg_addr = 4'h0;
        for (int c = 0; c < 2; c++) begin
            drive(4'h0, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'b1,
                  4'($urandom_range(15)), 1'b1, 4'($urandom_range(15)), 1'b1,
                  16'($urandom), 1'($urandom), 1'($urandom));
            reset_out = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk("reset result", result, 16'h0);
        chk("reset result_valid", result_valid, 1'b0);
        chk("reset flags", flags, 5'h0);
        for (int r = 0; r < 16; r++) begin
            dbg_addr = 4'(r);
            #1 chk($sformatf("reset R%0d", r), dbg_data, 16'h0);
        end
        nop(); reset_out = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.op, v.exop, v.rd, v.we, v.ra, v.aen, v.rb, v.ben, v.imm, v.rimm, v.cin);
            dbg_addr = v.creg;
            @(posedge clk); #1 nop();
            @(posedge clk); @(negedge clk);
            if (v.chk_res) chk($sformatf("vec%0d result", i), result, v.eres);
            chk($sformatf("vec%0d result_valid", i), result_valid, v.evalid);
            chk($sformatf("vec%0d flags", i), flags, v.eflags);
            chk($sformatf("vec%0d R%0d", i, v.creg), dbg_data, v.ereg);
        end

        // Back-to-back RAW chain: MOV R2, ADD R3=R2+1, ADD R4=R3+R2
        dbg_addr = 4'd2;
        drive(4'h0, 4'hD, 2, 1, 0, 0, 0, 0, 16'hABCD, 1, 0);
        @(posedge clk); #1;
        drive(4'h0, 4'h5, 3, 1, 2, 1, 0, 0, 16'h0001, 1, 0);
        @(negedge clk);
        chk("dbg R2 before write edge", dbg_data, 16'h1235);
        @(posedge clk); #1;
        chk("fwd mov result", result, 16'hABCD);
        chk("fwd mov valid", result_valid, 1'b1);
        chk("dbg R2 after write edge", dbg_data, 16'hABCD);
        drive(4'h0, 4'h5, 4, 1, 3, 1, 2, 1, 16'h0000, 0, 0);
        @(posedge clk); #1;
        chk("fwd add1 result", result, 16'hABCE);
        chk("fwd add1 valid", result_valid, 1'b1);
        chk("fwd add1 flags", flags, 5'h08);
        nop();
        @(posedge clk); #1;
        chk("fwd add2 result", result, 16'h579B);
        chk("fwd add2 valid", result_valid, 1'b1);
        chk("fwd add2 flags", flags, 5'h1C);
        dbg_addr = 4'd4;
        #1 chk("fwd R4", dbg_data, 16'h579B);
        @(posedge clk); #1;
        chk("idle valid low", result_valid, 1'b0);

        // Soft clear with a write in flight
        @(negedge clk);
        dbg_addr = 4'd5;
        drive(4'h0, 4'hD, 5, 1, 0, 0, 0, 0, 16'h5555, 1, 0);
        @(posedge clk); #1;
        nop(); reset_out = 1'b1;
        @(posedge clk); #1;
        reset_out = 1'b0;
        chk("soft clr result", result, 16'h0);
        chk("soft clr valid", result_valid, 1'b0);
        chk("soft clr flags", flags, 5'h0);
        for (int r = 0; r < 16; r++) begin
            dbg_addr = 4'(r);
            #1 chk($sformatf("soft clr R%0d", r), dbg_data, 16'h0);
        end
        @(posedge clk); #1;
        dbg_addr = 4'd5;
        #1 chk("soft clr pending write lost", dbg_data, 16'h0);
        chk("soft clr no late valid", result_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
